// File: rtl/unpacking_pkg.sv
// Shared constants and helpers for the packing/unpacking byte-stream blocks.
// Byte width, default beat size and a mask popcount.
package unpacking_pkg;

  localparam int BYTE_W = 8;
  localparam int N_DEF  = 10;
  localparam int MAX_N  = 64;

  function automatic int unsigned popcount(
    input logic [MAX_N-1:0] v
  );
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_N; i++)
      c = c + {31'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/unpacking_scatter.sv
// Scatter network: places the k-th oldest head byte
// at the k-th set mask position, scanning from the top lane.
module unpacking_scatter
  import unpacking_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0][BYTE_W-1:0] i_win,
  input  logic [N-1:0]             i_mask,
  output logic [N-1:0][BYTE_W-1:0] o_word
);

  localparam int KW = $clog2(N + 1);

  logic [KW-1:0] w_k;

  always_comb begin
    o_word = '0;
    w_k    = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (i_mask[j]) begin
        o_word[j] = i_win[w_k];
        w_k       = w_k + 1'b1;
      end
    end
  end

endmodule

// File: rtl/unpacking.sv
// Dense-to-sparse byte unpacker: buffers packed beats and
// scatters them into output words under a per-beat keep mask.
module unpacking
  import unpacking_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [8*N-1:0]      in_tdata,
  input  logic                in_tvalid,
  output logic                in_tready,
  input  logic [N-1:0]        mask_tkeep,
  input  logic                mask_tvalid,
  output logic                mask_tready,
  output logic [8*N-1:0]      out_tdata,
  output logic [N-1:0]        out_tkeep,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic [$clog2(2*N)-1:0] level
);

  localparam int D  = 2 * N - 1;
  localparam int AW = $clog2(2 * N);

  logic [BYTE_W-1:0] r_buf [D];
  logic [AW-1:0]     r_cnt;
  logic [8*N-1:0]    r_data;
  logic [N-1:0]      r_keep;
  logic              r_valid;

  logic [BYTE_W-1:0] w_nbuf [D];
  logic [N-1:0][BYTE_W-1:0] w_win;
  logic [N-1:0][BYTE_W-1:0] w_word;
  logic [AW-1:0] w_pc;
  logic [AW-1:0] w_sh;
  logic [AW-1:0] w_rem;
  logic          w_room;
  logic          w_acc;
  logic          w_fire;

  assign w_pc   = AW'(popcount(MAX_N'(mask_tkeep)));
  assign w_room = r_cnt <= AW'(N - 1);
  assign w_acc  = aresetn && in_tvalid && w_room;
  assign w_fire = aresetn && mask_tvalid
               && (r_cnt >= w_pc)
               && (!r_valid || out_tready);
  assign w_sh   = w_fire ? w_pc : '0;
  assign w_rem  = r_cnt - w_sh;

  assign in_tready   = aresetn && w_room;
  assign mask_tready = w_fire;
  assign out_tdata   = r_data;
  assign out_tkeep   = r_keep;
  assign out_tvalid  = r_valid;
  assign level       = r_cnt;

  always_comb begin
    for (int k = 0; k < N; k++)
      w_win[k] = r_buf[k];
  end

  unpacking_scatter #(.N(N)) u_scatter (
    .i_win  (w_win),
    .i_mask (mask_tkeep),
    .o_word (w_word)
  );

  // Drop consumed head bytes, then append the new beat
  // right behind whatever remains.
  always_comb begin
    for (int i = 0; i < D; i++)
      w_nbuf[i] = r_buf[i];
    for (int s = 1; s <= N; s++) begin
      if (w_sh == AW'(s)) begin
        for (int i = 0; i < D - s; i++)
          w_nbuf[i] = r_buf[i + s];
      end
    end
    for (int m = 0; m < N; m++) begin
      for (int i = 0; i < D; i++) begin
        if (w_acc && (w_rem + AW'(m)) == AW'(i))
          w_nbuf[i] = in_tdata[BYTE_W*(N-1-m) +: BYTE_W];
      end
    end
  end

  always_ff @(posedge aclk) begin
    r_buf <= w_nbuf;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cnt   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_cnt <= w_rem + (w_acc ? AW'(N) : '0);
      if (w_fire) begin
        r_data  <= w_word;
        r_keep  <= mask_tkeep;
        r_valid <= 1'b1;
      end else if (out_tready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unpacking.sv
// Bench for unpacking: directed scenarios plus random traffic
// checked against a byte-queue reference model.
module tb_unpacking;

  localparam int N  = 10;
  localparam int LW = $clog2(2 * N);

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [8*N-1:0] in_tdata;
  logic           in_tvalid;
  logic           in_tready;
  logic [N-1:0]   mask_tkeep;
  logic           mask_tvalid;
  logic           mask_tready;
  logic [8*N-1:0] out_tdata;
  logic [N-1:0]   out_tkeep;
  logic           out_tvalid;
  logic           out_tready;
  logic [LW-1:0]  level;

  always #5 aclk = ~aclk;

  unpacking #(.N(N)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .in_tdata    (in_tdata),
    .in_tvalid   (in_tvalid),
    .in_tready   (in_tready),
    .mask_tkeep  (mask_tkeep),
    .mask_tvalid (mask_tvalid),
    .mask_tready (mask_tready),
    .out_tdata   (out_tdata),
    .out_tkeep   (out_tkeep),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .level       (level)
  );

  logic [7:0]     q [$];
  logic           m_valid;
  logic [8*N-1:0] m_data;
  logic [N-1:0]   m_keep;
  logic           e_in_ready;
  logic           e_fire;
  logic           o_in_ready;
  logic           o_mask_ready;
  int             vec;
  int             errs;

  function automatic logic [8*N-1:0] s2w(input string s);
    logic [8*N-1:0] w;
    logic [7:0] c;
    w = '0;
    for (int i = 0; i < N; i++) begin
      c = s[i];
      w[8*(N-1-i) +: 8] = (c == 8'h30) ? 8'h00 : c;
    end
    return w;
  endfunction

  function automatic logic [8*N-1:0] rnd_word();
    logic [8*N-1:0] w;
    for (int i = 0; i < N; i++)
      w[8*i +: 8] = 8'($urandom);
    return w;
  endfunction

  // Advance one clock; ready outputs are sampled before the
  // edge and the queue model is updated after it.
  task automatic step();
    int pc;
    #1;
    o_in_ready   = in_tready;
    o_mask_ready = mask_tready;
    pc = $countones(mask_tkeep);
    e_in_ready = aresetn && (q.size() < N);
    e_fire = aresetn && mask_tvalid && (q.size() >= pc)
          && (!m_valid || out_tready);
    @(posedge aclk);
    #1;
    if (!aresetn) begin
      q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_keep  = '0;
    end else begin
      if (e_fire) begin
        m_data = '0;
        for (int j = N - 1; j >= 0; j--)
          if (mask_tkeep[j]) m_data[8*j +: 8] = q.pop_front();
        m_keep  = mask_tkeep;
        m_valid = 1'b1;
      end else if (out_tready) begin
        m_valid = 1'b0;
      end
      if (e_in_ready && in_tvalid)
        for (int k = 0; k < N; k++)
          q.push_back(in_tdata[8*(N-1-k) +: 8]);
    end
  endtask

  task automatic idle();
    in_tvalid   = 1'b0;
    in_tdata    = '0;
    mask_tvalid = 1'b0;
    mask_tkeep  = '0;
    out_tready  = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    aresetn     = 1'b0;
    mask_tvalid = 1'b1;
    in_tvalid   = 1'b1;
    step();
    step();
    vec++;
    if (out_tvalid !== 1'b0 || level !== '0) begin
      errs++;
      $display("FAIL rst_state valid=%b level=%0d want 0/0",
               out_tvalid, level);
    end
    vec++;
    if (out_tdata !== '0 || out_tkeep !== '0) begin
      errs++;
      $display("FAIL rst_data data=%h keep=%b want 0",
               out_tdata, out_tkeep);
    end
    vec++;
    if (o_in_ready !== 1'b0 || o_mask_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_ready in=%b mask=%b want 0/0",
               o_in_ready, o_mask_ready);
    end
    idle();
    aresetn = 1'b1;
    step();
    vec++;
    if (in_tready !== 1'b1) begin
      errs++;
      $display("FAIL rst_release in_tready=%b want 1", in_tready);
    end
  endtask

  task automatic test_single_beat();
    do_reset();
    in_tdata    = s2w("DEGIJKOQRS");
    in_tvalid   = 1'b1;
    mask_tkeep  = 10'b0001101011;
    mask_tvalid = 1'b1;
    step();
    in_tvalid = 1'b0;
    step();
    vec++;
    if (out_tdata !== s2w("000DE0G0IJ") || out_tvalid !== 1'b1) begin
      errs++;
      $display("FAIL single_data got %h v=%b want %h v=1",
               out_tdata, out_tvalid, s2w("000DE0G0IJ"));
    end
    vec++;
    if (out_tkeep !== 10'b0001101011 || level !== LW'(5)) begin
      errs++;
      $display("FAIL single_keep keep=%b level=%0d want 0001101011/5",
               out_tkeep, level);
    end
    in_tdata   = s2w("TUWXYZfhjl");
    in_tvalid  = 1'b1;
    mask_tkeep = 10'b1001001111;
    step();
    vec++;
    if (out_tvalid !== 1'b0 || o_mask_ready !== 1'b0) begin
      errs++;
      $display("FAIL carry_wait valid=%b mready=%b want 0/0",
               out_tvalid, o_mask_ready);
    end
    in_tvalid = 1'b0;
    step();
    vec++;
    if (out_tdata !== s2w("K00O00QRST") || level !== LW'(9)) begin
      errs++;
      $display("FAIL carry_data got %h lvl=%0d want %h lvl=9",
               out_tdata, level, s2w("K00O00QRST"));
    end
    idle();
    step();
  endtask

  task automatic test_zero_mask();
    do_reset();
    mask_tvalid = 1'b1;
    mask_tkeep  = '0;
    step();
    mask_tvalid = 1'b0;
    vec++;
    if (o_mask_ready !== 1'b1) begin
      errs++;
      $display("FAIL zero_ready mask_tready=%b want 1", o_mask_ready);
    end
    vec++;
    if (out_tvalid !== 1'b1 || out_tkeep !== '0
        || out_tdata !== '0 || level !== '0) begin
      errs++;
      $display("FAIL zero_beat v=%b keep=%b data=%h lvl=%0d want 1/0/0/0",
               out_tvalid, out_tkeep, out_tdata, level);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [8*N-1:0] d0;
    do_reset();
    in_tdata    = rnd_word();
    in_tvalid   = 1'b1;
    mask_tkeep  = 10'b1000000011;
    mask_tvalid = 1'b1;
    step();
    in_tvalid = 1'b0;
    step();
    d0 = out_tdata;
    vec++;
    if (d0 !== m_data || out_tvalid !== 1'b1) begin
      errs++;
      $display("FAIL bp_first got %h want %h", d0, m_data);
    end
    out_tready = 1'b0;
    in_tvalid  = 1'b1;
    in_tdata   = rnd_word();
    for (int c = 0; c < 5; c++) begin
      step();
      vec++;
      if (out_tdata !== d0 || out_tvalid !== 1'b1
          || out_tkeep !== 10'b1000000011) begin
        errs++;
        $display("FAIL bp_hold c=%0d got %h v=%b want %h v=1",
                 c, out_tdata, out_tvalid, d0);
      end
      vec++;
      if (o_mask_ready !== 1'b0 || o_in_ready !== e_in_ready) begin
        errs++;
        $display("FAIL bp_ready c=%0d m=%b in=%b want 0/%b",
                 c, o_mask_ready, o_in_ready, e_in_ready);
      end
    end
    vec++;
    if (level !== LW'(17) || in_tready !== 1'b0) begin
      errs++;
      $display("FAIL bp_level lvl=%0d in_tready=%b want 17/0",
               level, in_tready);
    end
    idle();
    step();
  endtask

  task automatic test_full_mask();
    logic [8*N-1:0] w1;
    logic [8*N-1:0] w2;
    logic [8*N-1:0] exp;
    do_reset();
    w1        = rnd_word();
    w2        = rnd_word();
    in_tdata  = w1;
    in_tvalid = 1'b1;
    step();
    in_tvalid   = 1'b0;
    mask_tkeep  = 10'b0000000001;
    mask_tvalid = 1'b1;
    step();
    mask_tkeep = '1;
    for (int c = 0; c < 3; c++) begin
      step();
      vec++;
      if (o_mask_ready !== 1'b0 || level !== LW'(9)) begin
        errs++;
        $display("FAIL full_wait c=%0d mready=%b lvl=%0d want 0/9",
                 c, o_mask_ready, level);
      end
    end
    in_tdata  = w2;
    in_tvalid = 1'b1;
    step();
    in_tvalid = 1'b0;
    step();
    exp = {w1[8*N-9:0], w2[8*N-1 -: 8]};
    vec++;
    if (out_tdata !== exp || out_tkeep !== '1 || level !== LW'(9)) begin
      errs++;
      $display("FAIL full_fire got %h lvl=%0d want %h lvl=9",
               out_tdata, level, exp);
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_tdata  = rnd_word();
    in_tvalid = 1'b1;
    step();
    in_tvalid   = 1'b0;
    out_tready  = 1'b0;
    mask_tkeep  = 10'b0000000111;
    mask_tvalid = 1'b1;
    step();
    vec++;
    if (level !== LW'(7) || out_tvalid !== 1'b1) begin
      errs++;
      $display("FAIL mid_setup lvl=%0d v=%b want 7/1", level, out_tvalid);
    end
    in_tvalid = 1'b1;
    aresetn   = 1'b0;
    step();
    vec++;
    if (out_tvalid !== 1'b0 || level !== '0
        || o_in_ready !== 1'b0 || o_mask_ready !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset v=%b lvl=%0d in=%b m=%b want 0/0/0/0",
               out_tvalid, level, o_in_ready, o_mask_ready);
    end
    idle();
    aresetn = 1'b1;
    step();
    vec++;
    if (in_tready !== 1'b1 || level !== '0) begin
      errs++;
      $display("FAIL mid_release in_tready=%b lvl=%0d want 1/0",
               in_tready, level);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      aresetn     = ($urandom_range(0, 79) != 0);
      in_tvalid   = ($urandom_range(0, 2) != 0);
      in_tdata    = rnd_word();
      mask_tvalid = ($urandom_range(0, 3) != 0);
      mask_tkeep  = N'($urandom);
      if ($urandom_range(0, 1) == 1) mask_tkeep &= N'($urandom);
      if ($urandom_range(0, 15) == 0) mask_tkeep = '1;
      if ($urandom_range(0, 15) == 0) mask_tkeep = '0;
      out_tready  = ($urandom_range(0, 3) != 0);
      step();
      vec++;
      if (o_in_ready !== e_in_ready || o_mask_ready !== e_fire) begin
        errs++;
        $display("FAIL rnd_ready c=%0d in=%b m=%b want %b/%b",
                 c, o_in_ready, o_mask_ready, e_in_ready, e_fire);
      end
      vec++;
      if (out_tvalid !== m_valid || level !== LW'(q.size())) begin
        errs++;
        $display("FAIL rnd_state c=%0d v=%b lvl=%0d want %b/%0d",
                 c, out_tvalid, level, m_valid, q.size());
      end
      if (m_valid) begin
        vec++;
        if (out_tdata !== m_data || out_tkeep !== m_keep) begin
          errs++;
          $display("FAIL rnd_data c=%0d got %h/%b want %h/%b",
                   c, out_tdata, out_tkeep, m_data, m_keep);
        end
      end
    end
    idle();
    aresetn = 1'b1;
    step();
  endtask

  initial begin
    vec     = 0;
    errs    = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_keep  = '0;
    aresetn = 1'b0;
    idle();
    test_reset();
    test_single_beat();
    test_zero_mask();
    test_backpressure();
    test_full_mask();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
